// File: rtl/iir_pkg.sv
//------------------------------------------------------------------------------
// Module      : iir_pkg
// Description : Shared types and requantizing helpers for the IIR datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package iir_pkg;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] q;
        logic        clip;
    } rq_t;

    function automatic logic [31:0] midscale(input int da_w);
        return 32'd1 << (da_w - 1);
    endfunction

    // Two's complement to offset binary: flip the sign bit of the w-bit word.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] q, input int w);
        return (q ^ (32'd1 << (w - 1))) & ((32'd1 << w) - 32'd1);
    endfunction

    // Half-up round by 'shift' bits, then clip into a signed w-bit range.
    function automatic rq_t round_sat(input int x, input int shift, input int w);
        int  r;
        int  hi;
        int  lo;
        rq_t res;
        r        = (x + (1 << (shift - 1))) >>> shift;
        hi       = (1 << (w - 1)) - 1;
        lo       = -(1 << (w - 1));
        res.q    = r;
        res.clip = 1'b0;
        if (r > hi) begin
            res.q    = hi;
            res.clip = 1'b1;
        end else if (r < lo) begin
            res.q    = lo;
            res.clip = 1'b1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iir_dac_tx_sample_fifo.sv
//------------------------------------------------------------------------------
// Module      : sample_fifo
// Description : Synchronous FIFO with registered occupancy, full and empty.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [$clog2(DEPTH):0]  r_count;
    logic                    w_wr;
    logic                    w_rd;

    assign o_full    = (r_count == ($clog2(DEPTH)+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/iir_dac_tx.sv
//------------------------------------------------------------------------------
// Module      : iir_dac_tx
// Description : Requantizes filter samples to offset binary and paces them to
//               a parallel DAC with a generated DAC clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iir_dac_tx
    import iir_pkg::*;
#(
    parameter int DIN_W      = 12,
    parameter int DA_W       = 10,
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME_LVL  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              clr,
    output logic              da_clk,
    output logic [DA_W-1:0]   da_data,
    output logic              underrun,
    output logic [15:0]       sat_cnt
);

    localparam int                  c_SHIFT    = DIN_W - DA_W;
    localparam int                  c_CNT_W    = $clog2(DIV);
    localparam int                  c_OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]  c_DIV_LAST = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF     = c_CNT_W'(DIV / 2);
    localparam logic [c_OCC_W-1:0]  c_PRIME    = c_OCC_W'(PRIME_LVL);
    localparam logic [DA_W-1:0]     c_MID      = DA_W'(midscale(DA_W));

    logic [c_CNT_W-1:0]  r_div_cnt;
    logic                r_da_clk;
    logic [DA_W-1:0]     r_da_data;
    state_t              r_state;
    logic                r_underrun;
    logic [15:0]         r_sat_cnt;

    logic [c_CNT_W-1:0]  w_div_nxt;
    logic                w_strobe;
    rq_t                 w_rq;
    logic [DA_W-1:0]     w_wr_word;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_OCC_W-1:0]  w_count;
    logic [DA_W-1:0]     w_head;

    assign w_strobe  = (r_div_cnt == c_DIV_LAST);
    assign w_div_nxt = w_strobe ? '0 : r_div_cnt + 1'b1;
    assign din_ready = ~w_full;
    assign w_push    = din_valid & ~w_full;
    assign w_pop     = w_strobe & (r_state == RUN) & ~w_empty;

    always_comb begin
        w_rq      = round_sat(int'($signed(din)), c_SHIFT, DA_W);
        w_wr_word = DA_W'(to_offset_bin(w_rq.q, DA_W));
    end

    sample_fifo #(
        .WIDTH (DA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // da_clk follows the next divider value so it falls together with a new da_data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div_cnt  <= '0;
            r_da_clk   <= 1'b0;
            r_da_data  <= c_MID;
            r_state    <= PRIME;
            r_underrun <= 1'b0;
            r_sat_cnt  <= '0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_da_clk  <= (w_div_nxt >= c_HALF);

            if (clr) begin
                r_underrun <= 1'b0;
            end

            if (w_push && w_rq.clip) begin
                if (clr) begin
                    r_sat_cnt <= 16'd1;
                end else if (r_sat_cnt != 16'hFFFF) begin
                    r_sat_cnt <= r_sat_cnt + 16'd1;
                end
            end else if (clr) begin
                r_sat_cnt <= '0;
            end

            if (w_strobe) begin
                case (r_state)
                    PRIME: begin
                        if (w_count >= c_PRIME) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!w_empty) begin
                            r_da_data <= w_head;
                        end else begin
                            r_underrun <= 1'b1;
                            r_state    <= PRIME;
                        end
                    end
                    default: r_state <= PRIME;
                endcase
            end
        end
    end

    assign da_clk   = r_da_clk;
    assign da_data  = r_da_data;
    assign underrun = r_underrun;
    assign sat_cnt  = r_sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_iir_dac_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_iir_dac_tx
// Description : Directed self-checking bench for iir_dac_tx.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iir_dac_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        clr;
    logic        da_clk;
    logic [9:0]  da_data;
    logic        underrun;
    logic [15:0] sat_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          k     = 0;

    int          occ_m;
    int          v;
    int          npop;
    bit          run_m;
    bit          rdy;
    bit          psh;
    bit          stb;
    bit          pp;
    logic [9:0]  exp_d;

    always #5 sys_clk = ~sys_clk;

    iir_dac_tx #(
        .DIN_W      (12),
        .DA_W       (10),
        .DIV        (4),
        .FIFO_DEPTH (4),
        .PRIME_LVL  (2)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .clr       (clr),
        .da_clk    (da_clk),
        .da_data   (da_data),
        .underrun  (underrun),
        .sat_cnt   (sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied at a falling edge are taken at the next rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            k++;
        end
    endtask

    task automatic to_phase(input int p);
        for (int g = 0; g < 4 && (k % 4) != p; g++) begin
            step(1);
        end
    endtask

    task automatic push(input logic [11:0] d);
        chk("din_ready_at_push", 32'(din_ready), 32'd1);
        din       = d;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        clr       = 1'b0;
        #1 sys_rst_n = 1'b0;

        // 1: reset values and DAC clock shape
        @(negedge sys_clk);
        chk("rst_da_data", 32'(da_data), 32'h200);
        chk("rst_da_clk", 32'(da_clk), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            chk("da_clk_wave", 32'(da_clk), 32'((k % 4) >= 2));
            step(1);
        end
        chk("idle_da_data", 32'(da_data), 32'h200);

        // 2: rounding
        push(12'h005);
        push(12'h006);
        push(12'hFFA);
        to_phase(0);
        step(4); chk("round_005", 32'(da_data), 32'h201);
        step(4); chk("round_006", 32'(da_data), 32'h202);
        step(4); chk("round_FFA", 32'(da_data), 32'h1FF);
        chk("round_sat_cnt", 32'(sat_cnt), 32'd0);
        step(4);
        chk("round_hold", 32'(da_data), 32'h1FF);
        chk("round_underrun", 32'(underrun), 32'd1);
        pulse_clr();
        chk("clr_underrun_a", 32'(underrun), 32'd0);
        to_phase(0);

        // 3: saturation
        push(12'h7FF);
        push(12'h800);
        to_phase(0);
        step(4); chk("sat_7FF", 32'(da_data), 32'h3FF);
        step(4); chk("sat_800", 32'(da_data), 32'h000);
        chk("sat_cnt_one", 32'(sat_cnt), 32'd1);
        step(4); chk("sat_underrun", 32'(underrun), 32'd1);
        pulse_clr();
        chk("clr_underrun_b", 32'(underrun), 32'd0);
        chk("clr_sat_cnt_b", 32'(sat_cnt), 32'd0);
        to_phase(0);

        // 4: backpressure with a ramp, tracked by a small occupancy model
        occ_m = 0; v = 0; npop = 0; run_m = 1'b0; exp_d = 10'h000;
        for (int i = 0; i < 52; i++) begin
            din_valid = (i < 32);
            din       = 12'(4 * v);
            rdy       = (occ_m < 4);
            chk("bp_din_ready", 32'(din_ready), 32'(rdy));
            psh = din_valid && rdy;
            stb = ((k % 4) == 3);
            pp  = stb && run_m && (occ_m > 0);
            if (stb) begin
                if (!run_m && occ_m >= 2) run_m = 1'b1;
                else if (run_m && occ_m == 0) run_m = 1'b0;
            end
            if (pp) begin
                exp_d = 10'h200 + 10'(npop);
                npop++;
            end
            occ_m = occ_m + int'(psh) - int'(pp);
            if (psh) v++;
            step(1);
            chk("bp_da_data", 32'(da_data), 32'(exp_d));
        end
        din_valid = 1'b0;
        chk("bp_underrun", 32'(underrun), 32'd1);
        pulse_clr();
        to_phase(0);

        // 5: underrun, resume, clear
        push(12'h010);
        push(12'h020);
        to_phase(0);
        step(4); chk("ur_word1", 32'(da_data), 32'h204);
        step(4); chk("ur_word2", 32'(da_data), 32'h208);
        chk("ur_not_yet", 32'(underrun), 32'd0);
        step(4); chk("ur_hold", 32'(da_data), 32'h208);
        chk("ur_flag", 32'(underrun), 32'd1);
        push(12'h030);
        push(12'h7FF);
        to_phase(0);
        step(4); chk("resume_word1", 32'(da_data), 32'h20C);
        step(4); chk("resume_word2", 32'(da_data), 32'h3FF);
        chk("resume_sat_cnt", 32'(sat_cnt), 32'd1);
        pulse_clr();
        chk("clr_underrun_c", 32'(underrun), 32'd0);
        chk("clr_sat_cnt_c", 32'(sat_cnt), 32'd0);
        clr = 1'b1;
        push(12'h7FE);
        clr = 1'b0;
        chk("clip_beats_clr", 32'(sat_cnt), 32'd1);
        to_phase(0);
        chk("round_up_clip", 32'(da_data), 32'h3FF);
        step(8);
        chk("ur_again", 32'(underrun), 32'd1);
        to_phase(0);

        // 6: reset in RUN with three samples buffered
        push(12'h040);
        push(12'h050);
        to_phase(0);
        push(12'h060);
        step(1);
        chk("pre_rst_da_clk", 32'(da_clk), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_da_data", 32'(da_data), 32'h200);
        chk("mid_rst_da_clk", 32'(da_clk), 32'd0);
        chk("mid_rst_din_ready", 32'(din_ready), 32'd1);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;
        step(12);
        chk("post_rst_flushed", 32'(da_data), 32'h200);
        push(12'h0FE);
        step(8);
        chk("post_rst_one_sample", 32'(da_data), 32'h200);
        push(12'hF00);
        to_phase(0);
        step(4); chk("post_rst_word1", 32'(da_data), 32'h240);
        step(4); chk("post_rst_word2", 32'(da_data), 32'h1C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
